// File: rtl/regfile_wb_arbiter_if.sv
// Bus bundle between the WB stage, the multicycle result path, decode and the regFile write port.
// master = the surrounding pipeline, slave = the arbiter.
interface regfile_wb_arbiter_if #(
  parameter int WORD_SIZE  = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int FIFO_DEPTH = 2
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic                  wb_we;
  logic [ADDR_WIDTH-1:0] wb_addr;
  logic [WORD_SIZE-1:0]  wb_data;
  logic                  wb_hold;
  logic                  mc_valid;
  logic                  mc_ready;
  logic [ADDR_WIDTH-1:0] mc_addr;
  logic [WORD_SIZE-1:0]  mc_data;
  logic                  mc_issue;
  logic [ADDR_WIDTH-1:0] mc_issue_addr;
  logic [ADDR_WIDTH-1:0] rs1_addr;
  logic [ADDR_WIDTH-1:0] rs2_addr;
  logic                  rs1_busy;
  logic                  rs2_busy;
  logic                  sb_conflict;
  logic                  rf_we;
  logic [ADDR_WIDTH-1:0] rf_addr;
  logic [WORD_SIZE-1:0]  rf_data;
  logic [CW-1:0]         fifo_count;

  modport master (
    output wb_we, wb_addr, wb_data, mc_valid, mc_addr, mc_data,
           mc_issue, mc_issue_addr, rs1_addr, rs2_addr,
    input  wb_hold, mc_ready, rs1_busy, rs2_busy, sb_conflict,
           rf_we, rf_addr, rf_data, fifo_count
  );

  modport slave (
    input  wb_we, wb_addr, wb_data, mc_valid, mc_addr, mc_data,
           mc_issue, mc_issue_addr, rs1_addr, rs2_addr,
    output wb_hold, mc_ready, rs1_busy, rs2_busy, sb_conflict,
           rf_we, rf_addr, rf_data, fifo_count
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Shares the regFile write port between the WB stage and buffered multicycle results,
// and tracks which registers still await a multicycle result.
module regfile_wb_arbiter #(
  parameter int WORD_SIZE  = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int FIFO_DEPTH = 2,
  parameter int MAX_STARVE = 4
) (
  input logic clk_i,
  input logic rst_i,
  regfile_wb_arbiter_if.slave bus
);
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CW   = PW + 1;
  localparam int AGW  = $clog2(MAX_STARVE + 1);
  localparam int NREG = 2 ** ADDR_WIDTH;
  localparam logic [CW-1:0]  DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [AGW-1:0] STARVE_C = AGW'(MAX_STARVE);

  logic [ADDR_WIDTH-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [WORD_SIZE-1:0]  fifo_data_q [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [AGW-1:0]        age_q, age_d;
  logic [NREG-1:0]       pending_q, pending_d;

  logic                  wb_req;
  logic                  fifo_empty;
  logic                  mc_ready;
  logic                  push;
  logic                  pop;
  logic                  head_go;
  logic                  issue_vld;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [WORD_SIZE-1:0]  head_data;

  assign wb_req     = bus.wb_we & (bus.wb_addr != '0);
  assign fifo_empty = (count_q == '0);
  assign mc_ready   = ~rst_i & (count_q < DEPTH_C);
  // x0 results are acknowledged but never stored
  assign push       = bus.mc_valid & mc_ready & (bus.mc_addr != '0);
  assign head_addr  = fifo_addr_q[rd_ptr_q];
  assign head_data  = fifo_data_q[rd_ptr_q];
  assign head_go    = ~fifo_empty & (~wb_req | (age_q >= STARVE_C));
  assign pop        = head_go & ~rst_i;
  assign issue_vld  = bus.mc_issue & (bus.mc_issue_addr != '0);

  assign bus.mc_ready    = mc_ready;
  assign bus.fifo_count  = count_q;
  assign bus.rs1_busy    = ~rst_i & pending_q[bus.rs1_addr];
  assign bus.rs2_busy    = ~rst_i & pending_q[bus.rs2_addr];
  assign bus.sb_conflict = ~rst_i & issue_vld & pending_q[bus.mc_issue_addr];

  always_comb begin
    bus.rf_we   = 1'b0;
    bus.rf_addr = '0;
    bus.rf_data = '0;
    bus.wb_hold = 1'b0;
    if (!rst_i) begin
      if (head_go) begin
        bus.rf_we   = 1'b1;
        bus.rf_addr = head_addr;
        bus.rf_data = head_data;
        bus.wb_hold = wb_req;
      end else if (wb_req) begin
        bus.rf_we   = 1'b1;
        bus.rf_addr = bus.wb_addr;
        bus.rf_data = bus.wb_data;
      end
    end
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    age_d     = age_q;
    pending_d = pending_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (fifo_empty || pop) begin
      age_d = '0;
    end else if (age_q < STARVE_C) begin
      age_d = age_q + AGW'(1);
    end
    // a same-cycle issue to the popped register keeps it pending
    if (pop)       pending_d[head_addr]         = 1'b0;
    if (issue_vld) pending_d[bus.mc_issue_addr] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      age_q     <= '0;
      pending_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      age_q     <= age_d;
      pending_q <= pending_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= bus.mc_addr;
      fifo_data_q[wr_ptr_q] <= bus.mc_data;
    end
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: queue-based reference model checked every negedge,
// plus directed scenarios with literal expectations.
module tb_regfile_wb_arbiter;
  localparam int WS = 32;
  localparam int AW = 5;
  localparam int FD = 2;
  localparam int MS = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_err = 0;

  regfile_wb_arbiter_if #(.WORD_SIZE(WS), .ADDR_WIDTH(AW), .FIFO_DEPTH(FD)) bus();

  regfile_wb_arbiter #(
    .WORD_SIZE(WS), .ADDR_WIDTH(AW), .FIFO_DEPTH(FD), .MAX_STARVE(MS)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Reference model: queue of {addr,data}, head wait counter, pending bit per register.
  logic [AW+WS-1:0] mq[$];
  int               age = 0;
  bit [31:0]        pend = '0;

  always @(negedge clk) begin
    logic            wbreq, hgo, ready;
    logic            e_we, e_hold;
    logic [AW-1:0]   e_addr;
    logic [WS-1:0]   e_data;
    logic [AW+WS-1:0] head;
    int              sz;
    if (rst) begin
      chk("rst_rf_we", 32'(bus.rf_we), 0);
      chk("rst_wb_hold", 32'(bus.wb_hold), 0);
      chk("rst_mc_ready", 32'(bus.mc_ready), 0);
      chk("rst_sb_conflict", 32'(bus.sb_conflict), 0);
      chk("rst_rs1_busy", 32'(bus.rs1_busy), 0);
      chk("rst_rs2_busy", 32'(bus.rs2_busy), 0);
      mq.delete();
      age  = 0;
      pend = '0;
    end else begin
      sz     = mq.size();
      wbreq  = bus.wb_we && (bus.wb_addr != 0);
      hgo    = (sz != 0) && (!wbreq || age >= MS);
      ready  = sz < FD;
      e_we   = 1'b0;
      e_hold = 1'b0;
      e_addr = '0;
      e_data = '0;
      if (hgo) begin
        e_we   = 1'b1;
        e_addr = mq[0][AW+WS-1:WS];
        e_data = mq[0][WS-1:0];
        e_hold = wbreq;
      end else if (wbreq) begin
        e_we   = 1'b1;
        e_addr = bus.wb_addr;
        e_data = bus.wb_data;
      end
      chk("rf_we", 32'(bus.rf_we), 32'(e_we));
      chk("rf_addr", 32'(bus.rf_addr), 32'(e_addr));
      chk("rf_data", bus.rf_data, e_data);
      chk("wb_hold", 32'(bus.wb_hold), 32'(e_hold));
      chk("mc_ready", 32'(bus.mc_ready), 32'(ready));
      chk("fifo_count", 32'(bus.fifo_count), 32'(sz));
      chk("rs1_busy", 32'(bus.rs1_busy), 32'(pend[bus.rs1_addr]));
      chk("rs2_busy", 32'(bus.rs2_busy), 32'(pend[bus.rs2_addr]));
      chk("sb_conflict", 32'(bus.sb_conflict),
          32'(bus.mc_issue && bus.mc_issue_addr != 0 && pend[bus.mc_issue_addr]));
      if (hgo) begin
        head = mq.pop_front();
        pend[head[AW+WS-1:WS]] = 1'b0;
      end
      if (bus.mc_valid && ready && bus.mc_addr != 0) mq.push_back({bus.mc_addr, bus.mc_data});
      if (bus.mc_issue && bus.mc_issue_addr != 0) pend[bus.mc_issue_addr] = 1'b1;
      if (sz == 0 || hgo) age = 0;
      else if (age < MS) age = age + 1;
    end
  end

  task automatic idle();
    bus.wb_we = 0; bus.wb_addr = '0; bus.wb_data = '0;
    bus.mc_valid = 0; bus.mc_addr = '0; bus.mc_data = '0;
    bus.mc_issue = 0; bus.mc_issue_addr = '0;
    bus.rs1_addr = '0; bus.rs2_addr = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit ok;
    idle();
    repeat (2) tick();
    rst = 0;
    tick();

    // 1: plain WB write, zero latency
    bus.wb_we = 1; bus.wb_addr = 5; bus.wb_data = 32'hDEADBEEF;
    mid();
    chk("t1_rf_we", 32'(bus.rf_we), 1);
    chk("t1_rf_addr", 32'(bus.rf_addr), 5);
    chk("t1_rf_data", bus.rf_data, 32'hDEADBEEF);
    chk("t1_wb_hold", 32'(bus.wb_hold), 0);
    tick();
    idle();

    // 2: issue, busy, result write-back, busy clears
    bus.mc_issue = 1; bus.mc_issue_addr = 7; bus.rs1_addr = 7;
    tick();
    bus.mc_issue = 0;
    bus.mc_valid = 1; bus.mc_addr = 7; bus.mc_data = 32'h12;
    mid();
    chk("t2_rs1_busy_set", 32'(bus.rs1_busy), 1);
    tick();
    bus.mc_valid = 0;
    mid();
    chk("t2_rf_we", 32'(bus.rf_we), 1);
    chk("t2_rf_addr", 32'(bus.rf_addr), 7);
    chk("t2_rf_data", bus.rf_data, 32'h12);
    tick();
    mid();
    chk("t2_rs1_busy_clr", 32'(bus.rs1_busy), 0);
    tick();

    // 3: starvation preemption after MAX_STARVE cycles
    bus.mc_valid = 1; bus.mc_addr = 10; bus.mc_data = 32'hA5;
    bus.wb_we = 1; bus.wb_addr = 4; bus.wb_data = 32'h100;
    tick();
    bus.mc_valid = 0;
    for (int i = 0; i < 6; i++) begin
      bus.wb_data = 32'(i);
      mid();
      chk("t3_rf_addr", 32'(bus.rf_addr), (i == 4) ? 10 : 4);
      chk("t3_wb_hold", 32'(bus.wb_hold), (i == 4) ? 1 : 0);
      tick();
    end

    // 4: fill, back-pressure, then pointer wrap
    bus.mc_valid = 1; bus.mc_addr = 11; bus.mc_data = 32'h1;
    tick();
    bus.mc_addr = 12; bus.mc_data = 32'h2;
    tick();
    bus.mc_valid = 0;
    mid();
    chk("t4_mc_ready_full", 32'(bus.mc_ready), 0);
    chk("t4_count_full", 32'(bus.fifo_count), 2);
    tick();
    bus.mc_valid = 1; bus.mc_addr = 13; bus.mc_data = 32'h3;
    ok = 0;
    for (int k = 0; k < 12; k++) begin
      mid();
      if (bus.mc_ready) begin
        ok = 1;
        tick();
        break;
      end
      tick();
    end
    chk("t4_third_accept", 32'(ok), 1);
    idle();
    repeat (4) tick();
    for (int i = 0; i < 5; i++) begin
      bus.mc_valid = 1; bus.mc_addr = AW'(16 + i); bus.mc_data = 32'(i * 3 + 1);
      tick();
      bus.mc_valid = 0;
      mid();
      chk("t4_wrap_addr", 32'(bus.rf_addr), 32'(16 + i));
      chk("t4_wrap_data", bus.rf_data, 32'(i * 3 + 1));
      tick();
    end

    // 5: x0 writes ignored; conflict pulse
    bus.wb_we = 1; bus.wb_addr = 0; bus.wb_data = 32'hFFFF;
    bus.mc_valid = 1; bus.mc_addr = 0; bus.mc_data = 32'h5;
    mid();
    chk("t5_rf_we", 32'(bus.rf_we), 0);
    chk("t5_wb_hold", 32'(bus.wb_hold), 0);
    tick();
    idle();
    mid();
    chk("t5_count", 32'(bus.fifo_count), 0);
    tick();
    bus.mc_issue = 1; bus.mc_issue_addr = 9;
    mid();
    chk("t5_no_conflict", 32'(bus.sb_conflict), 0);
    tick();
    mid();
    chk("t5_conflict", 32'(bus.sb_conflict), 1);
    tick();
    bus.mc_issue = 0;
    mid();
    chk("t5_conflict_end", 32'(bus.sb_conflict), 0);
    tick();

    // 6: reset with a full FIFO and a pending register
    bus.mc_issue = 1; bus.mc_issue_addr = 3; bus.rs1_addr = 3;
    tick();
    bus.mc_issue = 0;
    bus.wb_we = 1; bus.wb_addr = 4; bus.wb_data = 32'h44;
    bus.mc_valid = 1; bus.mc_addr = 3; bus.mc_data = 32'h33;
    tick();
    bus.mc_addr = 6; bus.mc_data = 32'h66;
    tick();
    bus.mc_valid = 0;
    mid();
    chk("t6_count_pre", 32'(bus.fifo_count), 2);
    chk("t6_busy_pre", 32'(bus.rs1_busy), 1);
    tick();
    rst = 1;
    mid();
    chk("t6_rf_we_rst", 32'(bus.rf_we), 0);
    tick();
    rst = 0;
    bus.wb_we = 0;
    mid();
    chk("t6_count_post", 32'(bus.fifo_count), 0);
    chk("t6_busy_post", 32'(bus.rs1_busy), 0);
    chk("t6_ready_post", 32'(bus.mc_ready), 1);
    tick();
    idle();
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
